// File: rtl/atm_pkg.sv
// Shared types and default sizes for the ATM transaction stage.
// Optional build macro: ATM_WD_LIMIT_EN (per-session withdraw cap).
package atm_pkg;
  localparam int BW_DEF       = 20;
  localparam int TIMEOUT_DEF  = 1000;
  localparam int WD_LIMIT_DEF = 5000;

  typedef enum logic [1:0] {OP_INQ, OP_DEP, OP_WD, OP_INV} op_e;
  typedef enum logic [1:0] {S_IDLE, S_READY, S_EXEC, S_DONE} state_e;
endpackage

// File: rtl/atm_op_alu.sv
// Combinational balance arithmetic for one request; on any error the balance passes through.
module atm_op_alu
  import atm_pkg::*;
#(
  parameter int balance_width = BW_DEF
) (
  input  op_e                      op,
  input  logic [balance_width-1:0] balance,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] result,
  output logic                     ovf,
  output logic                     funds
);
  localparam int BW = balance_width;

  logic [BW:0] sum;
  assign sum = {1'b0, balance} + {1'b0, amount};

  always_comb begin
    result = balance;
    ovf    = 1'b0;
    funds  = 1'b0;
    case (op)
      OP_DEP: begin
        if (sum[BW]) ovf = 1'b1;
        else         result = sum[BW-1:0];
      end
      OP_WD: begin
        if (amount > balance) funds = 1'b1;
        else                  result = balance - amount;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/atm_transaction.sv
// ATM session FSM: request latch, result/error registers, inactivity timeout.
// Optional build macro: ATM_WD_LIMIT_EN adds a cumulative withdraw cap (err_limit).
module atm_transaction
  import atm_pkg::*;
#(
  parameter int balance_width  = BW_DEF,
  parameter int timeout_cycles = TIMEOUT_DEF,
  parameter int wd_limit       = WD_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psw_en,
  input  logic                     card_out,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_start,
  input  logic [1:0]               op_sel,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] updated_balance,
  output logic                     op_done,
  output logic                     busy,
  output logic                     err_funds,
  output logic                     err_ovf,
  output logic                     err_op,
  output logic                     err_limit,
  output logic                     timeout
);
  localparam int BW = balance_width;
  localparam int TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;

  state_e          state;
  op_e             op_q;
  logic [BW-1:0]   amt_q;
  logic [TW-1:0]   tmo_cnt;
  logic [BW-1:0]   alu_result;
  logic            alu_ovf, alu_funds;
  logic            abort, enter_ready, exec_ok, lim_hit;

  // Session loss overrides every other transition, including a pending result.
  assign abort       = card_out | ~psw_en;
  assign enter_ready = (state == S_IDLE) & ~abort;
  assign exec_ok     = (state == S_EXEC) & ~abort;
  assign busy        = (state == S_EXEC) | (state == S_DONE);

  atm_op_alu #(.balance_width(BW)) u_alu (
    .op      (op_q),
    .balance (balance),
    .amount  (amt_q),
    .result  (alu_result),
    .ovf     (alu_ovf),
    .funds   (alu_funds)
  );

`ifdef ATM_WD_LIMIT_EN
  localparam int AW = BW + 2;
  logic [BW:0]   wd_acc;
  logic [AW-1:0] wd_next;

  assign wd_next = {1'b0, wd_acc} + AW'(amt_q);
  // Insufficient funds is reported first, so the cap only judges affordable withdraws.
  assign lim_hit = (op_q == OP_WD) & ~alu_funds & (wd_next > AW'(wd_limit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              wd_acc <= '0;
    else if (enter_ready)                                  wd_acc <= '0;
    else if (exec_ok && op_q == OP_WD && !alu_funds && !lim_hit) wd_acc <= wd_next[BW:0];
  end
`else
  assign lim_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      op_q            <= OP_INQ;
      amt_q           <= '0;
      tmo_cnt         <= '0;
      updated_balance <= '0;
      op_done         <= 1'b0;
      err_funds       <= 1'b0;
      err_ovf         <= 1'b0;
      err_op          <= 1'b0;
      err_limit       <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      updated_balance <= '0;
      op_done         <= 1'b0;
      err_funds       <= 1'b0;
      err_ovf         <= 1'b0;
      err_op          <= 1'b0;
      err_limit       <= 1'b0;
      timeout         <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_READY;
            tmo_cnt <= '0;
          end
          S_READY: begin
            if (op_start) begin
              state   <= S_EXEC;
              op_q    <= op_e'(op_sel);
              amt_q   <= amount;
              tmo_cnt <= '0;
            end else if (tmo_cnt == TW'(timeout_cycles - 2)) begin
              state   <= S_IDLE;
              timeout <= 1'b1;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_EXEC: begin
            state           <= S_DONE;
            op_done         <= 1'b1;
            updated_balance <= lim_hit ? balance : alu_result;
            err_funds       <= alu_funds;
            err_ovf         <= alu_ovf;
            err_op          <= (op_q == OP_INV);
            err_limit       <= lim_hit;
          end
          default: state <= S_READY;
        endcase
      end
    end
  end
endmodule
